serial_buf_tx: RTL and testbench
================================

SERIAL_BUF_TX -- requirements
Module: serial_buf_tx

Parameters
REQ-001 BUFFLEN, 5, maximum bytes per transfer (1..255).
REQ-002 BIT_CYCLES, 416, CLK cycles per serial bit (2..1023).
REQ-003 DATA_BITS, 8, data bits per character (5..8).
REQ-004 PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 STOP_BITS, 1, stop bits per character (1 or 2).

Interface
REQ-006 CLK  input  1  single clock; all state changes on posedge.
REQ-007 RESET_N  input  1  asynchronous, active-low reset.
REQ-008 START  input  1  level request; a transfer is accepted on a posedge with START=1, state IDLE, and DONE=0.
REQ-009 NBYTES  input  8  number of bytes to send, sampled at accept.
REQ-010 BUFFER  input  8*BUFFLEN  [0:8*BUFFLEN-1] big-endian; byte k = BUFFER[8k:8k+7], with bit 8k+7 the LSB; sampled at accept.
REQ-011 TXD  output  1  registered serial line, idle high.
REQ-012 BUSY  output  1  high from accept until the last stop bit completes.
REQ-013 DONE  output  1  completion flag, held high until START is low.

Function
REQ-014 FSM states SHALL be IDLE, START_BIT, DATA, PARITY_BIT, STOP, and FINISH; every bit state SHALL last exactly BIT_CYCLES cycles, timed by a bit counter cleared on each state entry.
REQ-015 On accept, the block SHALL copy BUFFER into an internal shift register, clamp NBYTES to BUFFLEN, and latch the result; later changes to BUFFER, NBYTES, or START SHALL NOT affect the transfer.
REQ-016 TXD SHALL go low in the cycle after the accept edge (latency 1), and BUSY SHALL rise on the same edge.
REQ-017 Each character SHALL be sent as: 1 start bit (0), then the DATA_BITS low-order bits LSB first (BUFFER bit 8k+7 first), then the parity bit if PARITY!=0, then STOP_BITS stop bits (1).
REQ-018 The parity bit SHALL be the XOR of the transmitted data bits; odd mode inverts that XOR, and even mode uses it directly.
REQ-019 Bytes SHALL go out in order 0..N-1 with no idle gap: the next start bit immediately follows the last stop bit.
REQ-020 After the last stop bit of byte N-1, the FSM SHALL enter FINISH; on that edge BUSY goes 0 and DONE goes 1.
REQ-021 In FINISH, DONE SHALL stay 1 and TXD 1 while START=1; the first edge with START=0 clears DONE and returns to IDLE.
REQ-022 NBYTES=0 (after clamping) SHALL send no frame: the accept edge goes straight to FINISH, DONE=1 one cycle later, BUSY never rises, and TXD stays 1.
REQ-023 The byte counter SHALL be 8 bits wide and compare against the latched count, so there is no wrap-around.
REQ-024 The maximum transfer length SHALL be BUFFLEN*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BIT_CYCLES cycles from accept to the DONE edge.
REQ-025 START held high across FINISH SHALL NOT start a second transfer; a new transfer needs START low for at least one cycle in FINISH, then high again in IDLE.

Reset
REQ-026 While RESET_N=0, asynchronously: TXD=1, BUSY=0, DONE=0, FSM=IDLE, and all counters and the shift register cleared.
REQ-027 Reset asserted mid-character SHALL abort the transfer immediately, with TXD=1 and no partial stop/parity bits emitted.
REQ-028 After RESET_N deassertion, the first accept is possible on the next posedge.

Verification (BIT_CYCLES=4, BUFFLEN=2 unless stated)
REQ-029 8N1, NBYTES=1, BUFFER byte0=0x41, START pulse -> TXD after accept: 0,1,0,0,0,0,0,1,0,1, each held 4 cycles; DONE rises 40 cycles after accept.
REQ-030 8E1 and 8O1, byte 0x41 -> parity bit 0 (even) and 1 (odd); DONE at 44 cycles.
REQ-031 NBYTES=5 with bytes 0x55,0xAA and STOP_BITS=2 -> exactly 2 frames, no gap, DONE at 88 cycles; BUFFER changed mid-transfer is ignored.
REQ-032 NBYTES=0 -> DONE=1 one cycle after accept, BUSY stays 0, TXD constant 1.
REQ-033 START held high after DONE -> no retransmit; START low for 1 cycle, then high -> second transfer accepted.
REQ-034 RESET_N low during data bit 3 of byte0 -> TXD=1, BUSY=0 immediately; after release, a new transfer completes normally.

Source files
------------

// File: rtl/serial_buf_tx.sv
// serial_buf_tx
//   Sends a block of up to BUFFLEN bytes as back-to-back asynchronous serial
//   characters. Each character is a start bit (0), DATA_BITS data bits sent
//   LSB first, an optional parity bit, and STOP_BITS stop bits (1). Every bit
//   lasts BIT_CYCLES clocks. The block is captured whole when the request is
//   accepted, so the caller may change its inputs while the transfer runs.
//
// Ports
//   CLK      in   system clock, all state changes on posedge
//   RESET_N  in   asynchronous active-low reset
//   START    in   level request; accepted in IDLE while DONE is low
//   NBYTES   in   byte count, clamped to BUFFLEN and latched at accept
//   BUFFER   in   [0:8*BUFFLEN-1]; byte k = BUFFER[8k:8k+7], bit 8k+7 is its LSB
//   TXD      out  registered serial line, idles high
//   BUSY     out  high from accept until the last stop bit has completed
//   DONE     out  completion flag, held until START is seen low
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line high, waiting for START
// START_BIT  | driving the start bit of the current character
// DATA       | driving data bit data_idx of the current character
// PARITY_BIT | driving the parity bit (only when PARITY != 0)
// STOP       | driving stop bit stop_idx of the current character
// FINISH     | transfer complete, DONE held until START drops

module serial_buf_tx #(
  parameter int BUFFLEN    = 5,
  parameter int BIT_CYCLES = 416,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic [7:0]             NBYTES,
  input  logic [0:8*BUFFLEN-1]   BUFFER,
  output logic                   TXD,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int              CW        = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [7:0]      BUFFLEN_B = 8'(BUFFLEN);
  localparam logic            HAS_PAR   = (PARITY != 0);
  localparam logic            ODD_PAR   = (PARITY == 1);
  localparam logic            TWO_STOP  = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY_BIT,
    STOP,
    FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]             data_idx_q, data_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [7:0]             byte_cnt_q, byte_cnt_d;
  logic [7:0]             nbytes_q, nbytes_d;
  logic [0:8*BUFFLEN-1]   buf_q, buf_d;
  logic [7:0]             char_q, char_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   bit_tc;
  logic [7:0]             n_clamp;
  logic [0:8*BUFFLEN-1]   buf_next;

  assign bit_tc   = (bit_cnt_q == BIT_LAST);
  assign n_clamp  = (NBYTES > BUFFLEN_B) ? BUFFLEN_B : NBYTES;
  // byte 0 always sits in buf_q[0:7]; shifting toward index 0 exposes the next byte
  assign buf_next = buf_q << 8;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      data_idx_q <= '0;
      stop_idx_q <= 1'b0;
      byte_cnt_q <= '0;
      nbytes_q   <= '0;
      buf_q      <= '0;
      char_q     <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_idx_q <= data_idx_d;
      stop_idx_q <= stop_idx_d;
      byte_cnt_q <= byte_cnt_d;
      nbytes_q   <= nbytes_d;
      buf_q      <= buf_d;
      char_q     <= char_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // txd_d always reflects the bit of the state being entered, so TXD changes
  // on the same edge as the state register and stays glitch-free.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 1'b1;
    data_idx_d = data_idx_q;
    stop_idx_d = stop_idx_q;
    byte_cnt_d = byte_cnt_q;
    nbytes_d   = nbytes_q;
    buf_d      = buf_q;
    char_d     = char_q;
    par_d      = par_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        txd_d     = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        if (START && !done_q) begin
          nbytes_d   = n_clamp;
          byte_cnt_d = '0;
          buf_d      = BUFFER;
          if (n_clamp == 8'd0) begin
            // empty transfer: report completion without touching the line
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = START_BIT;
            busy_d  = 1'b1;
            txd_d   = 1'b0;
            char_d  = BUFFER[0:7];
            par_d   = 1'b0;
          end
        end
      end

      START_BIT: begin
        if (bit_tc) begin
          state_d    = DATA;
          bit_cnt_d  = '0;
          data_idx_d = '0;
          txd_d      = char_q[0];
        end
      end

      DATA: begin
        if (bit_tc) begin
          bit_cnt_d = '0;
          par_d     = par_q ^ char_q[0];
          char_d    = char_q >> 1;
          if (data_idx_q == DATA_LAST) begin
            if (HAS_PAR) begin
              state_d = PARITY_BIT;
              txd_d   = par_q ^ char_q[0] ^ ODD_PAR;
            end else begin
              state_d    = STOP;
              stop_idx_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            data_idx_d = data_idx_q + 3'd1;
            txd_d      = char_q[1];
          end
        end
      end

      PARITY_BIT: begin
        if (bit_tc) begin
          state_d    = STOP;
          bit_cnt_d  = '0;
          stop_idx_d = 1'b0;
          txd_d      = 1'b1;
        end
      end

      STOP: begin
        if (bit_tc) begin
          bit_cnt_d = '0;
          txd_d     = 1'b1;
          if (TWO_STOP && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (byte_cnt_q == nbytes_q - 8'd1) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // next character follows with no idle gap
            state_d    = START_BIT;
            byte_cnt_d = byte_cnt_q + 8'd1;
            buf_d      = buf_next;
            char_d     = buf_next[0:7];
            par_d      = 1'b0;
            txd_d      = 1'b0;
          end
        end
      end

      FINISH: begin
        bit_cnt_d = '0;
        txd_d     = 1'b1;
        busy_d    = 1'b0;
        if (!START) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        txd_d     = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  assign TXD  = txd_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_serial_buf_tx.sv
// tb_serial_buf_tx
//   Four serial_buf_tx instances (8N1, 8E1, 8O1, 8N2; BUFFLEN=2, BIT_CYCLES=4)
//   share one set of inputs. For every transfer the expected per-cycle
//   {TXD,BUSY,DONE} of all four is pushed to a queue, then popped and
//   compared one clock at a time.

module tb_serial_buf_tx;

  localparam int BC = 4;
  localparam int BL = 2;
  localparam int PAR_T [4] = '{0, 2, 1, 0};
  localparam int STP_T [4] = '{1, 1, 1, 2};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        nbytes = '0;
  logic [0:8*BL-1]   buffer = '0;
  logic [3:0]        txd, busy, done;

  int                n_tests = 0;
  int                n_fail  = 0;
  logic [11:0]       exp_q [$];

  always #5 clk = ~clk;

  serial_buf_tx #(.BUFFLEN(BL), .BIT_CYCLES(BC), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .CLK(clk), .RESET_N(rst_n), .START(start), .NBYTES(nbytes), .BUFFER(buffer),
    .TXD(txd[0]), .BUSY(busy[0]), .DONE(done[0]));
  serial_buf_tx #(.BUFFLEN(BL), .BIT_CYCLES(BC), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .CLK(clk), .RESET_N(rst_n), .START(start), .NBYTES(nbytes), .BUFFER(buffer),
    .TXD(txd[1]), .BUSY(busy[1]), .DONE(done[1]));
  serial_buf_tx #(.BUFFLEN(BL), .BIT_CYCLES(BC), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .CLK(clk), .RESET_N(rst_n), .START(start), .NBYTES(nbytes), .BUFFER(buffer),
    .TXD(txd[2]), .BUSY(busy[2]), .DONE(done[2]));
  serial_buf_tx #(.BUFFLEN(BL), .BIT_CYCLES(BC), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .CLK(clk), .RESET_N(rst_n), .START(start), .NBYTES(nbytes), .BUFFER(buffer),
    .TXD(txd[3]), .BUSY(busy[3]), .DONE(done[3]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string inst_name(input int k);
    case (k)
      0:       return "8N1";
      1:       return "8E1";
      2:       return "8O1";
      default: return "8N2";
    endcase
  endfunction

  function automatic int bits_per_char(input int k);
    return 1 + 8 + ((PAR_T[k] != 0) ? 1 : 0) + STP_T[k];
  endfunction

  // line level for bit position idx of the frame stream of instance k
  function automatic logic frame_bit(input int k, input logic [7:0] b0, input logic [7:0] b1,
                                     input int idx);
    int         bpc;
    int         ch;
    int         pos;
    logic [7:0] byt;
    bpc = bits_per_char(k);
    ch  = idx / bpc;
    pos = idx % bpc;
    byt = (ch == 0) ? b0 : b1;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return byt[pos-1];
    if (pos == 9 && PAR_T[k] != 0) return (^byt) ^ (PAR_T[k] == 1);
    return 1'b1;
  endfunction

  // One transfer window: START high for the first 'hold' edges, 'len' edges
  // observed. Inputs are scrambled at edge 6 to prove they were latched.
  task automatic do_transfer(input string wname, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] nb, input int hold, input int len);
    int          n;
    int          flen;
    logic [11:0] e;
    n      = (nb > BL) ? BL : int'(nb);
    buffer = {b0, b1};
    nbytes = nb;
    for (int j = 0; j < len; j++) begin
      for (int k = 0; k < 4; k++) begin
        flen = n * bits_per_char(k) * BC;
        if (j < flen)
          e[3*k +: 3] = {frame_bit(k, b0, b1, j / BC), 1'b1, 1'b0};
        else
          e[3*k +: 3] = {1'b1, 1'b0, (j == flen) || (j < hold)};
      end
      exp_q.push_back(e);
    end
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      start = (j < hold);
      if (j == 6) begin
        buffer = ~{b0, b1};
        nbytes = 8'hFF;
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      for (int k = 0; k < 4; k++)
        check_val($sformatf("%s %s cyc%0d txd/busy/done", wname, inst_name(k), j),
                  {txd[k], busy[k], done[k]}, e[3*k +: 3]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check_val($sformatf("reset %s", inst_name(k)), {txd[k], busy[k], done[k]}, 3'b100);
    #1 rst_n = 1'b1;

    do_transfer("one_41",   8'h41, 8'h00, 8'd1,   1,  50);
    do_transfer("clamp",    8'h55, 8'hAA, 8'd5,   1,  95);
    do_transfer("zero",     8'h41, 8'h5A, 8'd0,   3,   6);
    do_transfer("hold",     8'h0F, 8'hF3, 8'd2, 100, 101);
    do_transfer("again",    8'hC8, 8'h00, 8'd1,   1,  50);
    do_transfer("pre_rst",  8'h41, 8'h00, 8'd1,   1,  18);

    // currently in data bit 3 of byte 0 (line low for 0x41)
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++)
      check_val($sformatf("rst_abort %s", inst_name(k)), {txd[k], busy[k], done[k]}, 3'b100);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check_val($sformatf("rst_hold %s", inst_name(k)), {txd[k], busy[k], done[k]}, 3'b100);
    #1 rst_n = 1'b1;

    do_transfer("post_rst", 8'h41, 8'h5A, 8'd2,   1,  95);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
